// File: rtl/display_bbox_scaler.sv
// display_bbox_scaler: collects one inference's box set in model coordinates.
// On a frame boundary it scales, clamps and orders the boxes into frame
// coordinates and emits exactly MAX_BBOX box words, one word per overlay slot.
// Optional feature macro: BBOX_MIN_SIZE_FILTER_EN (blanks boxes that are
// narrower or shorter than MIN_BBOX_SIZE after clamping).
// Handshake: a beat transfers on every rising clk edge where det_valid and
// det_ready are both high. det_ready is high only in IDLE and not in reset.
module display_bbox_scaler #(
  parameter int FRAME_WIDTH   = 640,
  parameter int FRAME_HEIGHT  = 480,
  parameter int MAX_BBOX      = 5,
  parameter int X_SCALE       = 1707,
  parameter int Y_SCALE       = 1280,
  parameter int MIN_BBOX_SIZE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] det_data,
  input  logic        det_valid,
  input  logic        det_last,
  output logic        det_ready,
  input  logic        frame_sync,
  output logic [63:0] bbox_data_out,
  output logic        bbox_data_out_valid,
  output logic        overflow,
  output logic        dbg_state_o
);

  localparam int CW = $clog2(MAX_BBOX + 1);
  localparam int EW = $clog2(MAX_BBOX + 3);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_BBOX);
  localparam logic [EW-1:0] ISSUE_N = EW'(MAX_BBOX);
  localparam logic [EW-1:0] LAST_E  = EW'(MAX_BBOX + 2);
  localparam logic [31:0]   XS      = 32'(X_SCALE);
  localparam logic [31:0]   YS      = 32'(Y_SCALE);
  localparam logic [15:0]   XMAX    = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0]   YMAX    = 16'(FRAME_HEIGHT - 1);
`ifdef BBOX_MIN_SIZE_FILTER_EN
  localparam logic [15:0]   MIN_SZ  = 16'(MIN_BBOX_SIZE);
`else
  localparam int min_size_unused = MIN_BBOX_SIZE;
`endif

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] emit_cnt_q, emit_cnt_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] c_cnt_q, d_cnt_q;
  logic [63:0]   coll_q [MAX_BBOX];
  logic [63:0]   disp_q [MAX_BBOX];
  logic          accept, is_empty, store, drop, commit, start, issue;
  logic [63:0]   rd_word;
  logic          s1_v_q, s1_blank_q;
  logic [31:0]   s1_px0_q, s1_py0_q, s1_px1_q, s1_py1_q;
  logic          s2_v_q;
  logic [63:0]   s2_data_q, s2_word;
  logic [15:0]   sx0, sy0, sx1, sy1, cx0, cy0, cx1, cy1, lx, ly, hx, hy;

  assign det_ready   = (state_q == IDLE) & ~rst;
  assign dbg_state_o = state_q;

  // Beat classification: store, drop on full buffer, commit on last beat.
  always_comb begin
    accept   = det_valid & det_ready;
    is_empty = (det_data == '1);
    store    = accept & ~is_empty & (c_cnt_q < MAX_C);
    drop     = accept & ~is_empty & (c_cnt_q == MAX_C);
    commit   = accept & det_last;
    start    = (state_q == IDLE) & frame_sync & (pending_q | commit);
    issue    = (state_q == EMIT) & (emit_cnt_q < ISSUE_N);
  end

  // Next-state logic: EMIT runs until the last word has left the output register.
  always_comb begin
    state_d    = state_q;
    emit_cnt_d = emit_cnt_q;
    pending_d  = pending_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = EMIT;
          emit_cnt_d = '0;
          pending_d  = 1'b0;
        end else if (commit) begin
          pending_d = 1'b1;
        end
      end
      EMIT: begin
        if (emit_cnt_q == LAST_E) state_d = IDLE;
        else emit_cnt_d = emit_cnt_q + EW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      emit_cnt_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      emit_cnt_q <= emit_cnt_d;
      pending_q  <= pending_d;
    end
  end

  // Counts and sticky overflow; a commit hands the collected count to display.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_cnt_q  <= '0;
      d_cnt_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (commit) begin
        d_cnt_q <= c_cnt_q + CW'(store);
        c_cnt_q <= '0;
      end else if (store) begin
        c_cnt_q <= c_cnt_q + CW'(1);
      end
    end
  end

  // Buffer storage; the committing beat's box goes straight into display too.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_BBOX; i++) begin
      if (store && c_cnt_q == CW'(i)) coll_q[i] <= det_data;
      if (commit) disp_q[i] <= (store && c_cnt_q == CW'(i)) ? det_data : coll_q[i];
    end
  end

  // Display buffer read mux for the emission index.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < MAX_BBOX; i++) begin
      if (emit_cnt_q == EW'(i)) rd_word = disp_q[i];
    end
  end

  // Stage 1: scale products and blank flag for slots past the committed count.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_blank_q <= 1'b0;
      s1_px0_q   <= '0;
      s1_py0_q   <= '0;
      s1_px1_q   <= '0;
      s1_py1_q   <= '0;
    end else begin
      s1_v_q     <= issue;
      s1_blank_q <= (emit_cnt_q >= EW'(d_cnt_q));
      s1_px0_q   <= 32'(rd_word[63:48]) * XS;
      s1_py0_q   <= 32'(rd_word[47:32]) * YS;
      s1_px1_q   <= 32'(rd_word[31:16]) * XS;
      s1_py1_q   <= 32'(rd_word[15:0])  * YS;
    end
  end

  // Stage 2 combinational: drop fraction, clamp to frame, order corners.
  always_comb begin
    sx0 = 16'(s1_px0_q >> 8);
    sy0 = 16'(s1_py0_q >> 8);
    sx1 = 16'(s1_px1_q >> 8);
    sy1 = 16'(s1_py1_q >> 8);
    cx0 = (sx0 > XMAX) ? XMAX : sx0;
    cy0 = (sy0 > YMAX) ? YMAX : sy0;
    cx1 = (sx1 > XMAX) ? XMAX : sx1;
    cy1 = (sy1 > YMAX) ? YMAX : sy1;
    lx  = (cx0 > cx1) ? cx1 : cx0;
    hx  = (cx0 > cx1) ? cx0 : cx1;
    ly  = (cy0 > cy1) ? cy1 : cy0;
    hy  = (cy0 > cy1) ? cy0 : cy1;
    s2_word = {lx, ly, hx, hy};
`ifdef BBOX_MIN_SIZE_FILTER_EN
    if (((hx - lx) < MIN_SZ) || ((hy - ly) < MIN_SZ)) s2_word = '1;
`endif
    if (s1_blank_q) s2_word = '1;
  end

  // Stage 2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
    end else begin
      s2_v_q    <= s1_v_q;
      s2_data_q <= s2_word;
    end
  end

  // Output register: data holds its last value between emissions.
  always_ff @(posedge clk) begin
    if (rst) begin
      bbox_data_out       <= '0;
      bbox_data_out_valid <= 1'b0;
    end else begin
      bbox_data_out_valid <= s2_v_q;
      if (s2_v_q) bbox_data_out <= s2_data_q;
    end
  end

endmodule

// File: tb/tb_display_bbox_scaler.sv
// Bench for display_bbox_scaler: directed stimulus, a behavioural model that
// predicts every output word and its cycle, and literal pins on key words.
module tb_display_bbox_scaler;

  localparam int MAXB = 5;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] det_data = '0;
  logic        det_valid = 1'b0;
  logic        det_last = 1'b0;
  logic        det_ready;
  logic        frame_sync = 1'b0;
  logic [63:0] bbox_data_out;
  logic        bbox_data_out_valid;
  logic        overflow;
  logic        dbg_state;

  display_bbox_scaler #(
    .FRAME_WIDTH(640), .FRAME_HEIGHT(480), .MAX_BBOX(MAXB),
    .X_SCALE(1707), .Y_SCALE(1280), .MIN_BBOX_SIZE(4)
  ) dut (
    .clk(clk), .rst(rst),
    .det_data(det_data), .det_valid(det_valid), .det_last(det_last),
    .det_ready(det_ready), .frame_sync(frame_sync),
    .bbox_data_out(bbox_data_out), .bbox_data_out_valid(bbox_data_out_valid),
    .overflow(overflow), .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int edge_n = 0;

  // model state
  logic [63:0] m_coll[$];
  logic [63:0] m_disp[$];
  bit          m_pending = 0;
  bit          m_ovf = 0;
  int          idle_from = 0;
  logic [63:0] exp_q[$];
  int          exp_edge[$];
  logic [63:0] got_q[$];
  logic [63:0] m_last = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
  endtask

  function automatic logic [15:0] sc(input logic [15:0] v, input int unsigned s, input int unsigned lim);
    int unsigned p;
    int unsigned r;
    p = int'(v) * s;
    r = (p / 256) % 65536;
    if (r > lim) r = lim;
    return 16'(r);
  endfunction

  function automatic logic [63:0] frame_word(input logic [63:0] raw);
    logic [15:0] x0, y0, x1, y1, lx, hx, ly, hy;
    x0 = sc(raw[63:48], 1707, 639);
    y0 = sc(raw[47:32], 1280, 479);
    x1 = sc(raw[31:16], 1707, 639);
    y1 = sc(raw[15:0],  1280, 479);
    lx = (x0 < x1) ? x0 : x1;  hx = (x0 < x1) ? x1 : x0;
    ly = (y0 < y1) ? y0 : y1;  hy = (y0 < y1) ? y1 : y0;
`ifdef BBOX_MIN_SIZE_FILTER_EN
    if (int'(hx) - int'(lx) < 4 || int'(hy) - int'(ly) < 4) return ONES;
`endif
    return {lx, ly, hx, hy};
  endfunction

  function automatic logic [63:0] box(input int x0, input int y0, input int x1, input int y1);
    return {16'(x0), 16'(y0), 16'(x1), 16'(y1)};
  endfunction

  // driver: one clock with the given inputs, model advanced at that edge
  task automatic tick(input logic v, input logic [63:0] d, input logic l, input logic fs);
    int n;
    bit idle, cmt;
    det_valid = v; det_data = d; det_last = l; frame_sync = fs;
    @(posedge clk);
    #1;
    idle = (edge_n >= idle_from);
    n = edge_n + 1;
    edge_n = n;
    if (!rst && idle) begin
      cmt = 0;
      if (v) begin
        if (d != ONES) begin
          if (m_coll.size() < MAXB) m_coll.push_back(d);
          else m_ovf = 1;
        end
        if (l) begin
          m_disp = m_coll;
          m_coll.delete();
          cmt = 1;
        end
      end
      if (fs && (m_pending || cmt)) begin
        m_pending = 0;
        for (int k = 0; k < MAXB; k++) begin
          exp_q.push_back(k < m_disp.size() ? frame_word(m_disp[k]) : ONES);
          exp_edge.push_back(n + 3 + k);
        end
        idle_from = n + 8;
      end else if (cmt) begin
        m_pending = 1;
      end
    end
    det_valid = 1'b0; det_last = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic idle_n(input int c);
    for (int i = 0; i < c; i++) tick(1'b0, '0, 1'b0, 1'b0);
  endtask

  // scoreboard: compare outputs against the model every cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_edge.size() > 0 && exp_edge[0] == edge_n) begin
        check("out_valid", 64'(bbox_data_out_valid), 64'd1);
        check("out_data", bbox_data_out, exp_q[0]);
        m_last = exp_q[0];
        got_q.push_back(bbox_data_out);
        void'(exp_q.pop_front());
        void'(exp_edge.pop_front());
      end else begin
        check("out_idle_valid", 64'(bbox_data_out_valid), 64'd0);
        check("out_hold_data", bbox_data_out, m_last);
      end
      check("det_ready", 64'(det_ready), 64'(edge_n >= idle_from));
      check("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  int base;

  initial begin
    // reset
    rst = 1'b1;
    idle_n(3);
    rst = 1'b0;
    idle_from = edge_n;
    idle_n(2);

    // one box, then frame_sync
    base = got_q.size();
    tick(1'b1, box(10, 20, 50, 60), 1'b1, 1'b0);
    idle_n(2);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle_n(10);
    check("single_box_lit", got_q[base], box(66, 100, 333, 300));
    check("single_slot1_lit", got_q[base + 1], ONES);
    check("single_slot4_lit", got_q[base + 4], ONES);

    // clamp and swap
    base = got_q.size();
    tick(1'b1, box(96, 96, 0, 0), 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle_n(10);
    check("clamp_swap_lit", got_q[base], box(0, 0, 639, 479));

    // seven boxes: five kept, overflow sticky
    base = got_q.size();
    for (int i = 0; i < 7; i++)
      tick(1'b1, box(i * 8, i * 4, i * 8 + 40, i * 4 + 30), 1'b0 + logic'(i == 6), 1'b0);
    check("ovf_set_lit", 64'(overflow), 64'd1);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle_n(10);
    check("ovf_box0_lit", got_q[base], box(0, 0, 266, 150));
    check("ovf_box4_lit", got_q[base + 4], box(213, 80, 480, 230));
    check("ovf_sticky_lit", 64'(overflow), 64'd1);

    // empty-marker set clears everything; a repeat frame_sync emits nothing
    base = got_q.size();
    tick(1'b1, ONES, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle_n(10);
    check("empty_slot0_lit", got_q[base], ONES);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle_n(10);
    check("no_pending_cnt_lit", 64'(got_q.size() - base), 64'd5);

    // frame_sync during emission is ignored
    base = got_q.size();
    tick(1'b1, box(10, 20, 50, 60), 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle_n(1);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle_n(12);
    check("busy_fs_cnt_lit", 64'(got_q.size() - base), 64'd5);

    // commit and frame_sync in the same cycle
    base = got_q.size();
    tick(1'b1, box(100, 50, 20, 10), 1'b1, 1'b1);
    idle_n(10);
    check("same_cycle_lit", got_q[base], box(133, 50, 639, 250));

    // zero-width box next to a normal one
    base = got_q.size();
    tick(1'b1, box(10, 10, 10, 40), 1'b0, 1'b0);
    tick(1'b1, box(10, 20, 50, 60), 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle_n(10);
`ifdef BBOX_MIN_SIZE_FILTER_EN
    check("filter_slot0_lit", got_q[base], ONES);
`else
    check("filter_slot0_lit", got_q[base], box(66, 50, 66, 200));
`endif
    check("filter_slot1_lit", got_q[base + 1], box(66, 100, 333, 300));

    check("all_words_seen", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
